// File: rtl/vga_fill_scheduler.sv
// Round-robin arbiter and one-pixel-per-cycle rectangle rasteriser for the VGA framebuffer write port.
// Define VGA_FILL_CLIP_EN to step over (not plot) pixels outside H_RES x V_RES.
module vga_fill_scheduler #(
   parameter int unsigned COLOUR_W = 3,
   parameter int unsigned H_RES    = 640,
   parameter int unsigned V_RES    = 480
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [19:0]             req_x0,
   input  logic [19:0]             req_y0,
   input  logic [19:0]             req_w,
   input  logic [19:0]             req_h,
   input  logic [2*COLOUR_W-1:0]   req_colour,
   output logic [1:0]              req_done,
   input  logic                    wr_ready,
   output logic [9:0]              out_x,
   output logic [9:0]              out_y,
   output logic [18:0]             out_addr,
   output logic [COLOUR_W-1:0]     out_colour,
   output logic                    out_plot
);

`ifdef VGA_FILL_CLIP_EN
   localparam logic CLIP_EN = 1'b1;
`else
   localparam logic CLIP_EN = 1'b0;
`endif
   localparam logic [10:0] H_LIM = 11'(H_RES);
   localparam logic [10:0] V_LIM = 11'(V_RES);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t r_state;
   state_t w_next;

   logic                r_last_grant;
   logic                r_grant;
   logic [10:0]         r_x0;
   logic [10:0]         r_xend;
   logic [10:0]         r_yend;
   logic [10:0]         r_cx;
   logic [10:0]         r_cy;
   logic [COLOUR_W-1:0] r_colour;
   logic                r_plot;

   logic                w_any;
   logic                w_gnt;
   logic                w_accept;
   logic                w_empty;
   logic                w_row_end;
   logic                w_last;
   logic                w_adv;
   logic                w_cand_on;
   logic [9:0]          w_sel_x0;
   logic [9:0]          w_sel_y0;
   logic [9:0]          w_sel_w;
   logic [9:0]          w_sel_h;
   logic [COLOUR_W-1:0] w_sel_col;
   logic [10:0]         w_cand_x;
   logic [10:0]         w_cand_y;
   logic [18:0]         w_y19;
   logic [18:0]         w_x19;

   // Requester selection: a tie goes to the one not granted last time.
   always_comb begin
      w_any     = |req_valid;
      w_gnt     = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
      w_sel_x0  = w_gnt ? req_x0[19:10] : req_x0[9:0];
      w_sel_y0  = w_gnt ? req_y0[19:10] : req_y0[9:0];
      w_sel_w   = w_gnt ? req_w[19:10]  : req_w[9:0];
      w_sel_h   = w_gnt ? req_h[19:10]  : req_h[9:0];
      w_sel_col = w_gnt ? req_colour[2*COLOUR_W-1:COLOUR_W] : req_colour[COLOUR_W-1:0];
      w_empty   = (w_sel_w == '0) || (w_sel_h == '0);
   end

   // Candidate pixel: the rectangle origin when idle, otherwise the raster successor.
   always_comb begin
      w_row_end = (r_cx + 11'd1) == r_xend;
      w_last    = w_row_end && ((r_cy + 11'd1) == r_yend);
      w_adv     = !r_plot || wr_ready;
      if (r_state == S_IDLE) begin
         w_cand_x = {1'b0, w_sel_x0};
         w_cand_y = {1'b0, w_sel_y0};
      end else if (w_row_end) begin
         w_cand_x = r_x0;
         w_cand_y = r_cy + 11'd1;
      end else begin
         w_cand_x = r_cx + 11'd1;
         w_cand_y = r_cy;
      end
      w_cand_on = !CLIP_EN || ((w_cand_x < H_LIM) && (w_cand_y < V_LIM));
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = w_empty ? S_DONE : S_FILL;
         S_FILL:  if (w_adv && w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      req_done  = '0;
      w_accept  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_accept         = 1'b1;
               req_ready[w_gnt] = 1'b1;
            end
         end
         S_DONE:  req_done[r_grant] = 1'b1;
         default: ;
      endcase
   end

   // Pixel register: loaded with the origin on accept, stepped whenever the port is free.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_x0         <= '0;
         r_xend       <= '0;
         r_yend       <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_colour     <= '0;
         r_plot       <= 1'b0;
      end else if (w_accept) begin
         r_grant      <= w_gnt;
         r_last_grant <= w_gnt;
         r_x0         <= {1'b0, w_sel_x0};
         r_xend       <= {1'b0, w_sel_x0} + {1'b0, w_sel_w};
         r_yend       <= {1'b0, w_sel_y0} + {1'b0, w_sel_h};
         r_cx         <= w_cand_x;
         r_cy         <= w_cand_y;
         r_colour     <= w_sel_col;
         r_plot       <= !w_empty && w_cand_on;
      end else if ((r_state == S_FILL) && w_adv) begin
         if (w_last) begin
            r_plot <= 1'b0;
         end else begin
            r_cx   <= w_cand_x;
            r_cy   <= w_cand_y;
            r_plot <= w_cand_on;
         end
      end
   end

   always_comb begin
      w_y19      = {9'd0, r_cy[9:0]};
      w_x19      = {9'd0, r_cx[9:0]};
      out_x      = r_cx[9:0];
      out_y      = r_cy[9:0];
      out_addr   = (w_y19 << 9) + (w_y19 << 7) + w_x19;
      out_colour = r_colour;
      out_plot   = r_plot;
   end

endmodule

// File: tb/tb_vga_fill_scheduler.sv
// Bench for vga_fill_scheduler: queue-based pixel model checked every cycle, plus directed literal cases.
// Build with VGA_FILL_CLIP_EN defined to exercise clipping.
module tb_vga_fill_scheduler;

   localparam int CW = 3;
`ifdef VGA_FILL_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_ready;
   logic [19:0]   req_x0 = '0;
   logic [19:0]   req_y0 = '0;
   logic [19:0]   req_w = '0;
   logic [19:0]   req_h = '0;
   logic [2*CW-1:0] req_colour = '0;
   logic [1:0]    req_done;
   logic          wr_ready = 1'b1;
   logic [9:0]    out_x;
   logic [9:0]    out_y;
   logic [18:0]   out_addr;
   logic [CW-1:0] out_colour;
   logic          out_plot;

   vga_fill_scheduler #(.COLOUR_W(CW), .H_RES(640), .V_RES(480)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_x0(req_x0), .req_y0(req_y0), .req_w(req_w), .req_h(req_h),
      .req_colour(req_colour), .req_done(req_done), .wr_ready(wr_ready),
      .out_x(out_x), .out_y(out_y), .out_addr(out_addr), .out_colour(out_colour),
      .out_plot(out_plot)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: a queue of the pixels still to be visited for the current grant.
   typedef struct { int x; int y; bit on; } pix_t;
   pix_t m_q[$];
   bit   m_busy = 0;
   bit   m_last = 1;
   bit   m_done_due = 0;
   int   m_g = 0;
   int   m_colour = 0;
   int   acc_cnt = 0;
   int   last_acc_r = 0;

   // Logs of what the DUT actually did, for directed literal checks.
   int   cyc = 0;
   int   plot_hi = 0;
   int   plot_addr[$];
   int   plot_cyc[$];
   int   grant_r[$];
   int   grant_cyc[$];
   int   done_r[$];
   int   done_cyc[$];

   logic [1:0] e_ready;
   logic [1:0] e_done;
   logic       e_plot;
   int         win;
   int         mx, my, mw, mh;
   pix_t       p;

   always @(negedge clk) begin
      cyc++;
      e_ready = '0;
      e_done  = '0;
      e_plot  = 1'b0;
      win = (req_valid == 2'b11) ? (m_last ? 0 : 1) : (req_valid[1] ? 1 : 0);
      if (m_done_due) e_done[m_g] = 1'b1;
      if (!m_busy && (req_valid != 2'b00)) e_ready[win] = 1'b1;
      chk("req_ready", {30'd0, req_ready}, {30'd0, e_ready});
      chk("req_done", {30'd0, req_done}, {30'd0, e_done});
      if (m_q.size() > 0) begin
         p = m_q[0];
         e_plot = p.on;
         chk("out_x", {22'd0, out_x}, p.x % 1024);
         chk("out_y", {22'd0, out_y}, p.y % 1024);
         if (p.on) begin
            chk("out_addr", {13'd0, out_addr}, p.y * 640 + p.x);
            chk("out_colour", {29'd0, out_colour}, m_colour);
         end
      end
      chk("out_plot", {31'd0, out_plot}, {31'd0, e_plot});

      if (out_plot === 1'b1) plot_hi++;
      if ((out_plot === 1'b1) && wr_ready) begin
         plot_addr.push_back(int'(out_addr));
         plot_cyc.push_back(cyc);
      end
      if (req_ready != 2'b00) begin
         grant_r.push_back(req_ready[1] ? 1 : 0);
         grant_cyc.push_back(cyc);
      end
      if (req_done != 2'b00) begin
         done_r.push_back(req_done[1] ? 1 : 0);
         done_cyc.push_back(cyc);
      end

      if (reset) begin
         m_q.delete();
         m_busy = 0;
         m_last = 1;
         m_done_due = 0;
      end else if (m_done_due) begin
         m_done_due = 0;
         m_busy = 0;
      end else if (m_q.size() > 0) begin
         if (!m_q[0].on || wr_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done_due = 1;
         end
      end else if (!m_busy && (req_valid != 2'b00)) begin
         m_g = win;
         m_last = (win == 1);
         m_busy = 1;
         acc_cnt++;
         last_acc_r = win;
         mx = int'(req_x0[win*10 +: 10]);
         my = int'(req_y0[win*10 +: 10]);
         mw = int'(req_w[win*10 +: 10]);
         mh = int'(req_h[win*10 +: 10]);
         m_colour = int'(req_colour[win*CW +: CW]);
         for (int j = 0; j < mh; j++)
            for (int i = 0; i < mw; i++) begin
               p.x = mx + i;
               p.y = my + j;
               p.on = !CLIP || ((p.x < 640) && (p.y < 480));
               m_q.push_back(p);
            end
         if (m_q.size() == 0) m_done_due = 1;
      end
   end

   task automatic set_cmd(input int r, input int x, input int y, input int w, input int h, input int c);
      req_x0[r*10 +: 10] = 10'(x);
      req_y0[r*10 +: 10] = 10'(y);
      req_w[r*10 +: 10]  = 10'(w);
      req_h[r*10 +: 10]  = 10'(h);
      req_colour[r*CW +: CW] = CW'(c);
   endtask

   task automatic issue(input int r, input int x, input int y, input int w, input int h, input int c);
      int seen;
      bit got;
      seen = acc_cnt;
      got = 0;
      set_cmd(r, x, y, w, h, c);
      req_valid[r] = 1'b1;
      for (int n = 0; n < 50 && !got; n++) begin
         @(posedge clk); #1;
         if (acc_cnt != seen) got = 1;
      end
      req_valid[r] = 1'b0;
      chk("accept_timeout", {31'd0, got}, 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'd0, m_busy}, 32'd0);
   endtask

   task automatic clear_logs();
      plot_addr.delete(); plot_cyc.delete();
      grant_r.delete(); grant_cyc.delete();
      done_r.delete(); done_cyc.delete();
      plot_hi = 0;
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic rand_cmd(input int r);
      int w, h, x, y;
      w = $urandom_range(0, 5);
      h = $urandom_range(0, 4);
      if (CLIP) begin
         x = $urandom_range(0, 1023);
         y = $urandom_range(0, 1023);
         if ($urandom_range(0, 2) == 0) begin x = 637; y = 478; end
      end else if ($urandom_range(0, 4) == 0) begin
         x = (w > 0) ? 640 - w : 639;
         y = (h > 0) ? 480 - h : 479;
      end else begin
         x = $urandom_range(0, 634);
         y = $urandom_range(0, 475);
      end
      set_cmd(r, x, y, w, h, $urandom_range(0, 7));
   endtask

   int seen_acc;
   int exp1 [6] = '{12810, 12811, 12812, 13450, 13451, 13452};
   int exp3 [4] = '{3205, 3206, 3207, 3208};
   int nd;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_plot", {31'd0, out_plot}, 32'd0);
      chk("rst_x", {22'd0, out_x}, 32'd0);
      chk("rst_y", {22'd0, out_y}, 32'd0);
      chk("rst_addr", {13'd0, out_addr}, 32'd0);
      chk("rst_done", {30'd0, req_done}, 32'd0);

      // Ties from reset alternate 0,1,0,1.
      clear_logs();
      set_cmd(0, 1, 1, 1, 1, 1);
      set_cmd(1, 2, 2, 1, 1, 2);
      seen_acc = acc_cnt;
      req_valid = 2'b11;
      for (int n = 0; n < 100 && acc_cnt < seen_acc + 4; n++) begin
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      wait_idle();
      chk("tie_g0", qget(grant_r, 0), 0);
      chk("tie_g1", qget(grant_r, 1), 1);
      chk("tie_g2", qget(grant_r, 2), 0);
      chk("tie_g3", qget(grant_r, 3), 1);

      // Basic 3x2 fill.
      clear_logs();
      wr_ready = 1'b1;
      issue(0, 10, 20, 3, 2, 5);
      wait_idle();
      chk("basic_n", plot_addr.size(), 6);
      for (int i = 0; i < 6; i++) chk("basic_addr", qget(plot_addr, i), exp1[i]);
      chk("basic_done_r", qget(done_r, 0), 0);
      chk("basic_done_lat", qget(done_cyc, 0) - qget(plot_cyc, 5), 1);

      // Stall three cycles on the second pixel.
      clear_logs();
      issue(0, 5, 5, 4, 1, 3);
      @(posedge clk); #1;
      wr_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      wr_ready = 1'b1;
      wait_idle();
      chk("stall_n", plot_addr.size(), 4);
      for (int i = 0; i < 4; i++) chk("stall_addr", qget(plot_addr, i), exp3[i]);
      chk("stall_hi", plot_hi, 7);

      // Empty rectangle.
      clear_logs();
      issue(0, 50, 50, 0, 5, 2);
      wait_idle();
      chk("empty_done_lat", qget(done_cyc, 0) - qget(grant_cyc, 0), 1);
      chk("empty_plot", plot_hi, 0);

`ifdef VGA_FILL_CLIP_EN
      clear_logs();
      issue(1, 638, 479, 4, 2, 6);
      wait_idle();
      chk("clip_n", plot_addr.size(), 2);
      chk("clip_a0", qget(plot_addr, 0), 307198);
      chk("clip_a1", qget(plot_addr, 1), 307199);
      chk("clip_done", done_r.size(), 1);
`endif

      // Randomised traffic with back-pressure.
      seen_acc = acc_cnt;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (acc_cnt != seen_acc) begin
            req_valid[last_acc_r] = 1'b0;
            seen_acc = acc_cnt;
         end
         wr_ready = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < 2; r++)
            if (!req_valid[r] && ($urandom_range(0, 3) == 0)) begin
               rand_cmd(r);
               req_valid[r] = 1'b1;
            end
      end
      req_valid = 2'b00;
      wr_ready = 1'b1;
      wait_idle();
      @(posedge clk); #1;

      // Reset on the fourth pixel of a 10x10 fill.
      clear_logs();
      issue(0, 100, 100, 10, 10, 7);
      repeat (3) begin @(posedge clk); #1; end
      chk("rst4_x", {22'd0, out_x}, 103);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_plot", {31'd0, out_plot}, 32'd0);
      chk("abort_x", {22'd0, out_x}, 32'd0);
      chk("abort_y", {22'd0, out_y}, 32'd0);
      chk("abort_addr", {13'd0, out_addr}, 32'd0);
      chk("abort_col", {29'd0, out_colour}, 32'd0);
      reset = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      nd = done_r.size();
      chk("abort_no_done", nd, 0);
      clear_logs();
      set_cmd(0, 1, 1, 1, 1, 1);
      set_cmd(1, 2, 2, 1, 1, 2);
      seen_acc = acc_cnt;
      req_valid = 2'b11;
      for (int n = 0; n < 50 && acc_cnt == seen_acc; n++) begin
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      wait_idle();
      chk("post_rst_grant", qget(grant_r, 0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
